// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving a downstream JK flip-flop: queues {j,k} patterns with repeat counts,
// plays them back without bubbles, and checks the returned q against an internal model.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [LEN_W-1:0] i_cmd_len,
  output logic             o_j,
  output logic             o_k,
  input  logic             i_q_fb,
  output logic             o_exp_q,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_mismatch
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {StIdle, StRun} state_t;

  logic [1:0]       r_op_mem  [DEPTH];
  logic [LEN_W-1:0] r_len_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_fill;

  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic             r_j;
  logic             r_k;
  logic             r_exp_q;
  logic             r_busy;
  logic             r_done;
  logic             r_mismatch;

  logic             w_full;
  logic             w_has_cmd;
  logic             w_push;
  logic             w_pop;
  logic             w_exp_q_nxt;
  logic [1:0]       w_head_op;
  logic [LEN_W-1:0] w_head_len;

  // Ready depends only on registered fill, so a pop never frees space for a same-cycle push.
  assign w_full      = (r_fill == CNT_W'(DEPTH));
  assign w_has_cmd   = (r_fill != '0);
  assign o_cmd_ready = ~w_full;
  assign w_push      = i_cmd_valid & ~w_full;
  assign w_pop       = w_has_cmd & ((r_state == StIdle) | (r_rem == '0));
  assign w_head_op   = r_op_mem[r_rd_ptr];
  assign w_head_len  = r_len_mem[r_rd_ptr];

  always_comb begin
    w_exp_q_nxt = r_exp_q;
    case ({r_j, r_k})
      2'b00:   w_exp_q_nxt = r_exp_q;
      2'b01:   w_exp_q_nxt = 1'b0;
      2'b10:   w_exp_q_nxt = 1'b1;
      default: w_exp_q_nxt = ~r_exp_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]  <= i_cmd_op;
      r_len_mem[r_wr_ptr] <= i_cmd_len;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + CNT_W'(1);
        2'b01:   r_fill <= r_fill - CNT_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_rem      <= '0;
      r_j        <= 1'b0;
      r_k        <= 1'b0;
      r_exp_q    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_exp_q <= w_exp_q_nxt;
      if (i_q_fb != r_exp_q) r_mismatch <= 1'b1;
      case (r_state)
        StIdle: begin
          if (w_has_cmd) begin
            r_state      <= StRun;
            r_busy       <= 1'b1;
            {r_j, r_k}   <= w_head_op;
            r_rem        <= w_head_len;
          end
        end
        StRun: begin
          if (r_rem != '0) begin
            r_rem <= r_rem - LEN_W'(1);
          end else if (w_has_cmd) begin
            {r_j, r_k} <= w_head_op;
            r_rem      <= w_head_len;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_j        = r_j;
  assign o_k        = r_k;
  assign o_exp_q    = r_exp_q;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_mismatch = r_mismatch;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: a driver expands each accepted command into per-cycle
// {j,k} entries; a monitor checks every cycle against that stream and a JK behavioural model.
module tb_jk_cmd_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             j, k, q_fb, exp_q, busy, done, mismatch;
  logic             jk_q;
  logic             force_inv;

  int n_pass   = 0;
  int n_total  = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [1:0] jk;
    int         avail;
    bit         first;
  } ent_t;

  ent_t sb_q[$];
  int   acc_q[$];

  jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_len   (cmd_len),
    .o_j         (j),
    .o_k         (k),
    .i_q_fb      (q_fb),
    .o_exp_q     (exp_q),
    .o_busy      (busy),
    .o_done      (done),
    .o_mismatch  (mismatch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Downstream JK flip-flop; force_inv corrupts the feedback path.
  always @(posedge clk or posedge rst) begin
    if (rst) jk_q <= 1'b0;
    else begin
      case ({j, k})
        2'b00:   jk_q <= jk_q;
        2'b01:   jk_q <= 1'b0;
        2'b10:   jk_q <= 1'b1;
        default: jk_q <= ~jk_q;
      endcase
    end
  end
  assign q_fb = jk_q ^ force_inv;

  function automatic logic jk_next(input logic q, input logic [1:0] p);
    if (p == 2'b01) return 1'b0;
    if (p == 2'b10) return 1'b1;
    if (p == 2'b11) return ~q;
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, expv, $time);
  endtask

  // Monitor: outputs after edge N are checked at negedge+2.
  initial begin
    logic       m_q, m_mis, m_prev_busy, e_busy;
    logic [1:0] e_jk;
    int         e_fill;
    m_q = 1'b0; m_mis = 1'b0; m_prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        sb_q.delete();
        acc_q.delete();
        m_q = 1'b0; m_mis = 1'b0; m_prev_busy = 1'b0;
      end else begin
        e_busy = (sb_q.size() > 0) && (sb_q[0].avail <= edge_cnt);
        e_jk   = 2'b00;
        if (e_busy) begin
          e_jk = sb_q[0].jk;
          if (sb_q[0].first) void'(acc_q.pop_front());
          void'(sb_q.pop_front());
        end
        e_fill = 0;
        foreach (acc_q[i]) if (acc_q[i] <= edge_cnt) e_fill++;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("jk", 32'({j, k}), 32'(e_jk));
        chk("exp_q", 32'(exp_q), 32'(m_q));
        chk("done", 32'(done), 32'(m_prev_busy && !e_busy));
        chk("cmd_ready", 32'(cmd_ready), 32'(e_fill < int'(DEPTH)));
        chk("mismatch", 32'(mismatch), 32'(m_mis));
        m_mis       = m_mis | (q_fb !== m_q);
        m_q         = jk_next(m_q, e_jk);
        m_prev_busy = e_busy;
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] op, input int len);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    while (!cmd_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk("send_timeout_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= len; i++)
      sb_q.push_back('{jk: op, avail: (i == 0) ? edge_cnt + 2 : 0, first: (i == 0)});
    acc_q.push_back(edge_cnt + 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb_q.size() > 0 || busy) && g < 600) begin
      @(negedge clk);
      g++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int len;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; force_inv = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exp_q", 32'(exp_q), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // Single set, then back-to-back
    send(2'b10, 2);
    wait_idle();
    send(2'b10, 0);
    send(2'b11, 1);
    send(2'b01, 0);
    wait_idle();

    // Full FIFO behind a long-running head
    send(2'b11, 15);
    for (int i = 0; i < 4; i++) send(2'($urandom_range(0, 3)), 1);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    send(2'b10, 0);
    wait_idle();

    // Pointer wrap, one command at a time
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      wait_idle();
    end

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      len = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
      send(2'($urandom_range(0, 3)), len);
    end
    wait_idle();

    // Feedback corruption for one edge
    send(2'b10, 4);
    repeat (2) @(negedge clk);
    force_inv = 1'b1;
    @(negedge clk);
    force_inv = 1'b0;
    repeat (3) @(negedge clk);
    chk("mismatch_sticky", 32'(mismatch), 32'd1);
    wait_idle();
    send(2'b11, 1);
    wait_idle();
    chk("mismatch_still_set", 32'(mismatch), 32'd1);

    // Reset during the 2nd cycle of a command with two queued
    send(2'b10, 5);
    send(2'b11, 1);
    send(2'b01, 2);
    #5 rst = 1'b1;
    #1;
    chk("mid_rst_j", 32'(j), 32'd0);
    chk("mid_rst_k", 32'(k), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_exp_q", 32'(exp_q), 32'd0);
    chk("mid_rst_mismatch", 32'(mismatch), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    send(2'b01, 1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
